// File: rtl/lb_ctrl.sv
// Load-buffer controller: small fully-associative table of loaded words in front of data memory.
// Load hits are served from the table; misses and stores go to memory one request at a time.
module lb_ctrl #(
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fcn,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_fcn,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              port_lb_table_valid,
  output logic [ADDR_W-1:0] port_lb_table_addr,
  output logic [DATA_W-1:0] port_lb_table_data
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

  state_t state, state_next;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag  [ENTRIES];
  logic [DATA_W-1:0]  data [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   last_idx;

  logic              op_fcn;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] resp_q;
  logic [ADDR_W-1:0] port_addr_q;
  logic [DATA_W-1:0] port_data_q;

  logic               accept;
  logic               fill;
  logic               hit;
  logic               any_invalid;
  logic [ENTRIES-1:0] match;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   victim;

  assign accept = req_valid && (state == IDLE);
  assign fill   = (state == MWAIT) && mem_resp_valid && !op_fcn;

  // A flush in the accept cycle turns a would-be hit into a miss.
  always_comb begin
    match   = '0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid[i] && (tag[i] == req_addr[ADDR_W-1:2]);
      if (match[i]) hit_idx = IDX_W'(i);
    end
    hit = (|match) && !flush;
  end

  always_comb begin
    victim      = rr_ptr;
    any_invalid = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim      = IDX_W'(i);
        any_invalid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (!req_fcn && hit) ? RESP : MREQ;
      MREQ:    if (mem_req_ready) state_next = MWAIT;
      MWAIT:   if (mem_resp_valid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == IDLE);
    mem_req_valid = (state == MREQ);
    resp_valid    = (state == RESP);
    resp_data     = (state == RESP) ? resp_q : '0;
  end

  assign mem_req_fcn   = op_fcn;
  assign mem_req_addr  = op_addr;
  assign mem_req_wdata = op_wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_fcn   <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      resp_q   <= '0;
    end else begin
      if (accept) begin
        op_fcn   <= req_fcn;
        op_addr  <= req_addr;
        op_wdata <= req_wdata;
        if (!req_fcn && hit) resp_q <= data[hit_idx];
      end
      if ((state == MWAIT) && mem_resp_valid) resp_q <= op_fcn ? '0 : mem_resp_data;
    end
  end

  // Flush clears everything, but a fill on the same edge still claims its entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid       <= '0;
      rr_ptr      <= '0;
      last_idx    <= '0;
      port_addr_q <= '0;
      port_data_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      if (flush) valid <= '0;
      else if (accept && req_fcn) valid <= valid & ~match;
      if (fill) begin
        valid[victim] <= 1'b1;
        tag[victim]   <= op_addr[ADDR_W-1:2];
        data[victim]  <= mem_resp_data;
        last_idx      <= victim;
        port_addr_q   <= {op_addr[ADDR_W-1:2], 2'b00};
        port_data_q   <= mem_resp_data;
        if (!any_invalid) rr_ptr <= rr_ptr + IDX_W'(1);
      end
    end
  end

  assign port_lb_table_valid = valid[last_idx];
  assign port_lb_table_addr  = port_addr_q;
  assign port_lb_table_data  = port_data_q;

endmodule

// File: tb/tb_lb_ctrl.sv
// Self-checking bench for lb_ctrl: directed transactions against a transaction-level table model,
// with a per-cycle compare process and a few hand-computed literal expectations.
module tb_lb_ctrl;

  localparam int ENTRIES = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_fcn, flush, mem_req_ready, mem_resp_valid;
  logic [31:0] req_addr, req_wdata, mem_resp_data;
  logic        req_ready, resp_valid, mem_req_valid, mem_req_fcn, port_lb_table_valid;
  logic [31:0] resp_data, mem_req_addr, mem_req_wdata, port_lb_table_addr, port_lb_table_data;

  always #5 clock = ~clock;

  lb_ctrl #(.ENTRIES(ENTRIES), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fcn(req_fcn),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_fcn(mem_req_fcn),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .port_lb_table_valid(port_lb_table_valid), .port_lb_table_addr(port_lb_table_addr),
    .port_lb_table_data(port_lb_table_data)
  );

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic check_en = 1'b0;

  logic        exp_ready, exp_resp, exp_mreq, exp_mfcn;
  logic [31:0] exp_resp_data, exp_maddr, exp_mwdata;

  logic        m_valid [ENTRIES];
  logic [31:0] m_addr  [ENTRIES];
  logic [31:0] m_data  [ENTRIES];
  int          m_ptr;
  int          m_last;

  logic        cmp_pv;
  logic [31:0] cmp_pa, cmp_pd;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic int model_lookup(input logic [31:0] a);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && (m_addr[i][31:2] == a[31:2])) return i;
    return -1;
  endfunction

  function automatic int model_valid_count();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
      m_data[i]  = '0;
    end
    m_ptr  = 0;
    m_last = -1;
  endtask

  task automatic model_flush();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_invalidate(input logic [31:0] a);
    for (int i = 0; i < ENTRIES; i++)
      if (m_addr[i][31:2] == a[31:2]) m_valid[i] = 1'b0;
  endtask

  // Lowest free slot first; otherwise round-robin, advancing only when it is used.
  task automatic model_pick(output int v);
    v = -1;
    for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) v = i;
    if (v < 0) begin
      v     = m_ptr;
      m_ptr = (m_ptr + 1) % ENTRIES;
    end
  endtask

  task automatic model_fill(input logic [31:0] a, input logic [31:0] d, input int v);
    m_valid[v] = 1'b1;
    m_addr[v]  = {a[31:2], 2'b00};
    m_data[v]  = d;
    m_last     = v;
  endtask

  task automatic set_idle_exp();
    exp_ready = 1'b1;
    exp_resp  = 1'b0;
    exp_mreq  = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // flush_mode: 0 none, 1 with the accept, 2 one cycle inside MWAIT, 3 with the memory response
  task automatic apply_stimulus(input logic fcn, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int ready_delay, input int resp_delay,
                                input int flush_mode, output logic [31:0] got);
    int idx;
    int victim;
    got       = '0;
    victim    = 0;
    req_valid = 1'b1;
    req_fcn   = fcn;
    req_addr  = addr;
    req_wdata = wdata;
    flush     = (flush_mode == 1);
    idx       = (!fcn && flush_mode != 1) ? model_lookup(addr) : -1;
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    if (flush_mode == 1) model_flush();
    else if (fcn) model_invalidate(addr);
    exp_ready = 1'b0;
    if (idx >= 0) begin
      exp_resp      = 1'b1;
      exp_resp_data = m_data[idx];
      got           = resp_data;
      step();
      set_idle_exp();
      return;
    end
    exp_mreq   = 1'b1;
    exp_mfcn   = fcn;
    exp_maddr  = addr;
    exp_mwdata = wdata;
    for (int i = 0; i < ready_delay; i++) begin
      mem_resp_valid = (i == 0);
      mem_resp_data  = 32'hBAD0_0000;
      step();
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    step();
    mem_req_ready = 1'b0;
    exp_mreq      = 1'b0;
    if (flush_mode == 2) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      model_flush();
    end
    for (int i = 0; i < resp_delay; i++) step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    flush          = (flush_mode == 3);
    if (!fcn) model_pick(victim);
    step();
    mem_resp_valid = 1'b0;
    flush          = 1'b0;
    if (flush_mode == 3) model_flush();
    if (!fcn) model_fill(addr, rdata, victim);
    exp_resp      = 1'b1;
    exp_resp_data = fcn ? 32'h0 : rdata;
    got           = resp_data;
    step();
    set_idle_exp();
  endtask

  always @(negedge clock) if (mem_req_valid && mem_req_ready) hs_count++;

  initial forever begin
    @(negedge clock);
    if (check_en) begin
      cmp_pv = 1'b0;
      cmp_pa = '0;
      cmp_pd = '0;
      if (m_last >= 0) begin
        cmp_pv = m_valid[m_last];
        cmp_pa = m_addr[m_last];
        cmp_pd = m_data[m_last];
      end
      check_output("req_ready", 32'(req_ready), 32'(exp_ready));
      check_output("resp_valid", 32'(resp_valid), 32'(exp_resp));
      if (exp_resp) check_output("resp_data", resp_data, exp_resp_data);
      check_output("mem_req_valid", 32'(mem_req_valid), 32'(exp_mreq));
      if (exp_mreq) begin
        check_output("mem_req_fcn", 32'(mem_req_fcn), 32'(exp_mfcn));
        check_output("mem_req_addr", mem_req_addr, exp_maddr);
        if (exp_mfcn) check_output("mem_req_wdata", mem_req_wdata, exp_mwdata);
      end
      check_output("port_valid", 32'(port_lb_table_valid), 32'(cmp_pv));
      check_output("port_addr", port_lb_table_addr, cmp_pa);
      check_output("port_data", port_lb_table_data, cmp_pd);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] got;
    int hs0;
    reset_n = 1'b0; req_valid = 1'b0; req_fcn = 1'b0; req_addr = '0; req_wdata = '0;
    flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    model_reset();
    set_idle_exp();
    exp_resp_data = '0; exp_mfcn = 1'b0; exp_maddr = '0; exp_mwdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check_output("rst_req_ready", 32'(req_ready), 32'h1);
    check_output("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_output("rst_resp_data", resp_data, 32'h0);
    check_output("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    check_output("rst_mem_req_fcn", 32'(mem_req_fcn), 32'h0);
    check_output("rst_mem_req_addr", mem_req_addr, 32'h0);
    check_output("rst_mem_req_wdata", mem_req_wdata, 32'h0);
    check_output("rst_port_valid", 32'(port_lb_table_valid), 32'h0);
    check_output("rst_port_addr", port_lb_table_addr, 32'h0);
    check_output("rst_port_data", port_lb_table_data, 32'h0);
    check_en = 1'b1;
    reset_n  = 1'b1;
    flush    = 1'b1;
    step();
    flush = 1'b0;

    $display("[TB] cold load");
    hs0 = hs_count;
    apply_stimulus(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 0, got);
    check_output("cold_resp_data", got, 32'hDEADBEEF);
    check_output("cold_mem_reqs", 32'(hs_count - hs0), 32'd1);
    check_output("cold_port_valid", 32'(port_lb_table_valid), 32'h1);
    check_output("cold_port_addr", port_lb_table_addr, 32'h100);

    $display("[TB] hit");
    hs0 = hs_count;
    apply_stimulus(1'b0, 32'h100, 32'h0, 32'h0, 0, 0, 0, got);
    check_output("hit_resp_data", got, 32'hDEADBEEF);
    check_output("hit_mem_reqs", 32'(hs_count - hs0), 32'd0);

    $display("[TB] store invalidation");
    hs0 = hs_count;
    apply_stimulus(1'b1, 32'h102, 32'h55, 32'h0, 1, 1, 0, got);
    check_output("store_resp_data", got, 32'h0);
    check_output("store_mem_reqs", 32'(hs_count - hs0), 32'd1);
    check_output("store_port_valid", 32'(port_lb_table_valid), 32'h0);
    hs0 = hs_count;
    apply_stimulus(1'b0, 32'h100, 32'h0, 32'h55, 0, 0, 0, got);
    check_output("after_store_miss", 32'(hs_count - hs0), 32'd1);
    check_output("after_store_data", got, 32'h55);

    $display("[TB] replacement");
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_flush();
    for (int i = 0; i < 5; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      apply_stimulus(1'b0, a, 32'h0, mem_word(a), 0, 0, 0, got);
    end
    check_output("evict_model_ptr", 32'(m_ptr), 32'd1);
    check_output("evict_model_slot", 32'(m_last), 32'd0);
    check_output("evict_port_addr", port_lb_table_addr, 32'h10);
    check_output("evict_port_data", port_lb_table_data, 32'h5A5A_0010);
    hs0 = hs_count;
    apply_stimulus(1'b0, 32'h0, 32'h0, mem_word(32'h0), 0, 0, 0, got);
    check_output("reload0_miss", 32'(hs_count - hs0), 32'd1);
    check_output("reload0_model_ptr", 32'(m_ptr), 32'd2);
    check_output("reload0_model_slot", 32'(m_last), 32'd1);
    hs0 = hs_count;
    apply_stimulus(1'b0, 32'h8, 32'h0, 32'h0, 0, 0, 0, got);
    check_output("load8_hit", 32'(hs_count - hs0), 32'd0);
    check_output("load8_data", got, 32'h5A5A_0008);
    hs0 = hs_count;
    apply_stimulus(1'b0, 32'h4, 32'h0, mem_word(32'h4), 0, 0, 0, got);
    check_output("load4_evicted_miss", 32'(hs_count - hs0), 32'd1);

    $display("[TB] memory backpressure");
    apply_stimulus(1'b0, 32'h200, 32'h0, mem_word(32'h200), 5, 1, 0, got);
    check_output("bp_resp_data", got, 32'h5A5A_0200);

    $display("[TB] flush during wait");
    apply_stimulus(1'b0, 32'h300, 32'h0, mem_word(32'h300), 0, 1, 2, got);
    check_output("flushwait_model_count", 32'(model_valid_count()), 32'd1);
    check_output("flushwait_model_slot", 32'(m_last), 32'd0);
    check_output("flushwait_port_valid", 32'(port_lb_table_valid), 32'h1);
    hs0 = hs_count;
    apply_stimulus(1'b0, 32'h10, 32'h0, mem_word(32'h10), 0, 0, 0, got);
    check_output("flushwait_old_miss", 32'(hs_count - hs0), 32'd1);

    $display("[TB] flush with fill");
    apply_stimulus(1'b0, 32'h400, 32'h0, mem_word(32'h400), 0, 0, 3, got);
    check_output("flushfill_model_slot", 32'(m_last), 32'd2);
    check_output("flushfill_port_valid", 32'(port_lb_table_valid), 32'h1);
    hs0 = hs_count;
    apply_stimulus(1'b0, 32'h300, 32'h0, mem_word(32'h300), 0, 0, 0, got);
    check_output("flushfill_old_miss", 32'(hs_count - hs0), 32'd1);

    $display("[TB] flush with would-be hit");
    hs0 = hs_count;
    apply_stimulus(1'b0, 32'h400, 32'h0, mem_word(32'h400), 0, 0, 1, got);
    check_output("flushhit_miss", 32'(hs_count - hs0), 32'd1);

    $display("[TB] reset during wait");
    req_valid = 1'b1; req_fcn = 1'b0; req_addr = 32'h500;
    step();
    req_valid = 1'b0;
    exp_ready = 1'b0; exp_mreq = 1'b1; exp_mfcn = 1'b0; exp_maddr = 32'h500;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    exp_mreq      = 1'b0;
    reset_n       = 1'b0;
    #1;
    model_reset();
    set_idle_exp();
    check_output("midrst_resp_valid", 32'(resp_valid), 32'h0);
    check_output("midrst_req_ready", 32'(req_ready), 32'h1);
    check_output("midrst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    check_output("midrst_mem_req_addr", mem_req_addr, 32'h0);
    check_output("midrst_port_valid", 32'(port_lb_table_valid), 32'h0);
    check_output("midrst_port_addr", port_lb_table_addr, 32'h0);
    check_output("midrst_port_data", port_lb_table_data, 32'h0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    step();
    mem_resp_valid = 1'b0;
    step();
    check_output("midrst_no_resp", 32'(resp_valid), 32'h0);
    reset_n = 1'b1;
    step();
    hs0 = hs_count;
    apply_stimulus(1'b0, 32'h400, 32'h0, mem_word(32'h400), 0, 0, 0, got);
    check_output("postrst_miss", 32'(hs_count - hs0), 32'd1);
    check_output("postrst_data", got, 32'h5A5A_0400);

    step();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lb_ctrl.md
# lb_ctrl

Load-buffer controller between the Sodor 5-stage core's memory stage and data memory. It holds a small fully-associative table of recently loaded words, serves load hits in one cycle, and sequences misses and stores to memory through a single outstanding request. It also exports the most recently filled entry on `port_lb_table_*`, which the two-copy noninterference benches compare for load-buffer divergence.

## Interface
- `ENTRIES`, 4: table entries; power of two, at least 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  controller can accept a request.
- `req_fcn`  in  1  request type: 0 = load, 1 = store.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data.
- `resp_valid`  out  1  one-cycle completion pulse; cannot be backpressured.
- `resp_data`  out  DATA_W  load data; 0 for stores.
- `flush`  in  1  invalidate all entries.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_fcn`  out  1  memory request type: 0 = load, 1 = store.
- `mem_req_addr`  out  ADDR_W  memory request address.
- `mem_req_wdata`  out  DATA_W  memory store data.
- `mem_resp_valid`  in  1  memory response or store acknowledge.
- `mem_resp_data`  in  DATA_W  memory load data.
- `port_lb_table_valid`  out  1  last-filled entry is still valid.
- `port_lb_table_addr`  out  ADDR_W  address of the last-filled entry.
- `port_lb_table_data`  out  DATA_W  data of the last-filled entry.

## Operation
- FSM states: IDLE, MREQ, MWAIT, RESP.
- `req_ready` is 1 only in IDLE.
- A request is accepted on `req_valid && req_ready`.
- Tag match compares word address `addr[ADDR_W-1:2]` on valid entries only.
- IDLE, load hit: data is latched and the FSM goes to RESP. No memory traffic.
- IDLE, load miss: address is latched and the FSM goes to MREQ with `mem_req_fcn`=0.
- IDLE, store: any matching entry is invalidated in the accept cycle. Address and data are latched and the FSM goes to MREQ with `mem_req_fcn`=1. Stores never allocate.
- MREQ: `mem_req_valid`=1. Address, data and fcn are held stable until `mem_req_ready`, then the FSM goes to MWAIT.
- MWAIT: waits for `mem_resp_valid`.
  - Load: fill the victim entry with `mem_resp_data`, latch that data for the response, and go to RESP.
  - Store: go to RESP with `resp_data`=0.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Victim selection:
  - Lowest-index invalid entry if one exists.
  - Otherwise the round-robin pointer. The pointer increments modulo ENTRIES only when it selects the victim.
- Observation ports:
  - On a fill they load the filled entry's address, data and valid=1.
  - They clear valid when that entry is invalidated by a store or by `flush`.
  - They clear valid when that entry is overwritten by a later fill; the later fill then becomes the new last-filled entry, so valid returns to 1.
- `flush`:
  - Clears every valid bit at the next edge, in any state.
  - The round-robin pointer is not reset.
  - An in-flight load miss still completes and fills its entry after the flush.
- Simultaneous cases:
  - `flush` together with an IDLE load that would hit: the load is treated as a miss.
  - `flush` together with a fill: the fill wins for that entry.
- `mem_resp_valid` outside MWAIT is ignored.

## Timing
- Reset values (asynchronous, `reset_n`=0):
  - FSM is IDLE, so `req_ready`=1.
  - `resp_valid`=0, `resp_data`=0.
  - `mem_req_valid`=0, `mem_req_fcn`=0, `mem_req_addr`=0, `mem_req_wdata`=0.
  - All valid bits 0, round-robin pointer 0.
  - `port_lb_table_valid`=0, `port_lb_table_addr`=0, `port_lb_table_data`=0.
- Reset asserted mid-transaction abandons it. No response is issued and no fill occurs.
- Hit: accept at edge N, `resp_valid` during cycle N+1, `req_ready`=1 again in cycle N+2.
- Miss or store:
  - Accept at edge N.
  - `mem_req_valid` from cycle N+1.
  - Edge M is the edge where `mem_req_ready`=1.
  - Edge K>M is the edge where `mem_resp_valid` is seen.
  - `resp_valid` during cycle K+1; for loads the fill is visible on the `port_lb_table_*` ports in the same cycle.
- Minimum miss latency, accept to `resp_valid`: 3 cycles.
- At most one outstanding memory request.

## Test plan
- Cold load: `flush` at reset; load 0x100; memory returns 0xDEADBEEF after 2 cycles.
  - Expect one `mem_req` with fcn=0 and addr=0x100.
  - Expect `resp_data`=0xDEADBEEF.
  - Expect port valid=1, addr=0x100.
- Hit: repeat the load of 0x100.
  - Expect `resp_valid` 1 cycle after accept, data 0xDEADBEEF.
  - Expect no `mem_req_valid`.
- Store invalidation: store 0x55 to 0x102 (same word as 0x100), then load 0x100.
  - Expect store `mem_req` with fcn=1 and wdata=0x55.
  - Expect port valid=0 after the store.
  - Expect the following load to miss.
- Replacement: with ENTRIES=4, load 0x0, 0x4, 0x8, 0xC, 0x10.
  - Expect 0x10 to evict entry 0 and the pointer to become 1.
  - Expect a reload of 0x0 to miss; it refills entry 1 and the pointer becomes 2.
- `mem_req_ready` held low for 5 cycles on a miss.
  - Expect `mem_req_valid`, addr and fcn stable for all 5 cycles.
  - Expect `req_ready`=0 throughout.
- Disruptions during a miss: assert `flush` during MWAIT, then the response arrives.
  - Expect all other entries invalid and the new entry filled.
  - Separately, assert `reset_n`=0 during MWAIT: expect no `resp_valid`, all outputs at reset values.
